// File: rtl/bg_pkg.sv
// Shared colour constants and flash state encoding for the scrolling background.
package bg_pkg;

  localparam logic [7:0] RGB_BLACK  = 8'h00;
  localparam logic [7:0] RGB_WHITE  = 8'hFF;
  localparam logic [7:0] RGB_YELLOW = 8'hFC;

  // Base band colours and their darker counterparts used on odd stripes.
  localparam logic [7:0] BAND_PALETTE [8] = '{
    8'hE0, 8'h1C, 8'h03, 8'hE3, 8'h1F, 8'h92, 8'h49, 8'hF0
  };
  localparam logic [7:0] STRIPE_ALT [8] = '{
    8'h60, 8'h0C, 8'h01, 8'h61, 8'h0D, 8'h49, 8'h24, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_t;

endpackage

// File: rtl/bg_scroll_counter.sv
// Horizontal scroll offset, stepped once per frame in either direction with wrap at FRAME_W.
module bg_scroll_counter #(
  parameter int FRAME_W     = 640,
  parameter int SCROLL_STEP = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        scrollEn,
  input  logic        scrollDir,
  output logic [10:0] offset
);

  logic [11:0] sum_raw;
  logic [11:0] diff_raw;
  logic [10:0] sum_adj;
  logic [10:0] diff_adj;
  logic [10:0] offset_next;

  // Wrap by conditional add/subtract; the 12th bit of diff_raw flags a negative result.
  always_comb begin
    sum_raw     = {1'b0, offset} + 12'(SCROLL_STEP);
    diff_raw    = {1'b0, offset} - 12'(SCROLL_STEP);
    sum_adj     = (sum_raw >= 12'(FRAME_W)) ? 11'(sum_raw - 12'(FRAME_W)) : sum_raw[10:0];
    diff_adj    = diff_raw[11] ? 11'(diff_raw + 12'(FRAME_W)) : diff_raw[10:0];
    offset_next = scrollDir ? diff_adj : sum_adj;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offset <= '0;
    end else if (startOfFrame && scrollEn) begin
      offset <= offset_next;
    end
  end

endmodule

// File: rtl/back_ground_scroll.sv
// Background generator: banded, scrolling vertical stripes framed by a border and inset
// bracket lines, with a frame-synchronous border flash burst.
module back_ground_scroll
  import bg_pkg::*;
#(
  parameter int FRAME_W        = 640,
  parameter int FRAME_H        = 480,
  parameter int BRACKET_OFFSET = 10,
  parameter int STRIPE_W       = 32,
  parameter int NUM_BANDS      = 4,
  parameter int SCROLL_STEP    = 1,
  parameter int FLASH_FRAMES   = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        scrollEn,
  input  logic        scrollDir,
  input  logic        flashReq,
  output logic [7:0]  BG_RGB,
  output logic        flashBusy
);

  localparam int STRIPE_LOG2 = $clog2(STRIPE_W);
  localparam logic [10:0] X_LAST  = 11'(FRAME_W - 1);
  localparam logic [10:0] Y_LAST  = 11'(FRAME_H - 1);
  localparam logic [10:0] BR_LO   = 11'(BRACKET_OFFSET);
  localparam logic [10:0] BR_X_HI = 11'(FRAME_W - 1 - BRACKET_OFFSET);
  localparam logic [10:0] BR_Y_HI = 11'(FRAME_H - 1 - BRACKET_OFFSET);

  logic [10:0]  offset;
  flash_state_t state;
  logic [7:0]   flash_cnt;

  logic [11:0]  col_raw;
  logic [10:0]  col;
  logic         parity;
  logic [14:0]  band_prod;
  logic [2:0]   band;
  logic         on_border;
  logic         on_bracket;
  logic         invert;
  logic [7:0]   colour;

  bg_scroll_counter #(
    .FRAME_W     (FRAME_W),
    .SCROLL_STEP (SCROLL_STEP)
  ) u_scroll (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .scrollEn     (scrollEn),
    .scrollDir    (scrollDir),
    .offset       (offset)
  );

  always_comb begin
    col_raw = {1'b0, pixelX} + {1'b0, offset};
    col     = (col_raw >= 12'(FRAME_W)) ? 11'(col_raw - 12'(FRAME_W)) : col_raw[10:0];
    parity  = |(col & (11'(1) << STRIPE_LOG2));

    // Band index by threshold compare instead of a divider: band = y*NUM_BANDS/FRAME_H.
    band_prod = {4'b0, pixelY} * 15'(NUM_BANDS);
    band      = '0;
    for (int unsigned k = 1; k < NUM_BANDS; k++) begin
      if (band_prod >= 15'(k * unsigned'(FRAME_H))) band = 3'(k);
    end

    on_border  = (pixelX == '0) || (pixelY == '0) || (pixelX == X_LAST) || (pixelY == Y_LAST);
    on_bracket = ((pixelY >= BR_LO) && (pixelY <= BR_Y_HI) &&
                  ((pixelX == BR_LO) || (pixelX == BR_X_HI))) ||
                 ((pixelX >= BR_LO) && (pixelX <= BR_X_HI) &&
                  ((pixelY == BR_LO) || (pixelY == BR_Y_HI)));
    invert     = (state == FLASH_ON);

    if (pixelX >= 11'(FRAME_W) || pixelY >= 11'(FRAME_H)) begin
      colour = RGB_BLACK;
    end else if (on_border) begin
      colour = invert ? ~RGB_YELLOW : RGB_YELLOW;
    end else if (on_bracket) begin
      colour = invert ? ~RGB_WHITE : RGB_WHITE;
    end else begin
      colour = parity ? STRIPE_ALT[band] : BAND_PALETTE[band];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      BG_RGB <= RGB_WHITE;
    end else begin
      BG_RGB <= colour;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      flash_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flashReq) begin
            state     <= FLASH_ON;
            flash_cnt <= '0;
          end
        end
        FLASH_ON, FLASH_OFF: begin
          if (startOfFrame) begin
            if (flash_cnt == 8'(FLASH_FRAMES - 1)) begin
              state     <= IDLE;
              flash_cnt <= '0;
            end else begin
              state     <= (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
              flash_cnt <= flash_cnt + 8'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          flash_cnt <= '0;
        end
      endcase
    end
  end

  assign flashBusy = (state != IDLE);

endmodule

// File: tb/tb_back_ground_scroll.sv
// Directed bench for back_ground_scroll: static pixel table plus scroll, flash and reset sequences.
module tb_back_ground_scroll;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        scrollEn;
  logic        scrollDir;
  logic        flashReq;
  logic [7:0]  BG_RGB;
  logic        flashBusy;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  back_ground_scroll #(
    .FRAME_W        (640),
    .FRAME_H        (480),
    .BRACKET_OFFSET (10),
    .STRIPE_W       (32),
    .NUM_BANDS      (4),
    .SCROLL_STEP    (1),
    .FLASH_FRAMES   (8)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .startOfFrame (startOfFrame),
    .scrollEn     (scrollEn),
    .scrollDir    (scrollDir),
    .flashReq     (flashReq),
    .BG_RGB       (BG_RGB),
    .flashBusy    (flashBusy)
  );

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic px_cycle(input logic [10:0] x, input logic [10:0] y);
    pixelX = x;
    pixelY = y;
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
  endtask

  initial begin
    // Expected colours at offset 0, idle flash: bands are 120 rows each at 4 bands.
    vecs[0]  = '{11'd0,   11'd100, 8'hFC, "border_left"};
    vecs[1]  = '{11'd10,  11'd100, 8'hFF, "bracket_left"};
    vecs[2]  = '{11'd639, 11'd479, 8'hFC, "border_corner"};
    vecs[3]  = '{11'd700, 11'd100, 8'h00, "off_x"};
    vecs[4]  = '{11'd100, 11'd700, 8'h00, "off_y"};
    vecs[5]  = '{11'd640, 11'd0,   8'h00, "off_x_edge"};
    vecs[6]  = '{11'd639, 11'd0,   8'hFC, "border_tr"};
    vecs[7]  = '{11'd40,  11'd200, 8'h0C, "band1_odd"};
    vecs[8]  = '{11'd20,  11'd50,  8'hE0, "band0_even"};
    vecs[9]  = '{11'd20,  11'd300, 8'h03, "band2_even"};
    vecs[10] = '{11'd20,  11'd470, 8'hE3, "band3_even"};
    vecs[11] = '{11'd629, 11'd200, 8'hFF, "bracket_right"};
    vecs[12] = '{11'd100, 11'd10,  8'hFF, "bracket_top"};
    vecs[13] = '{11'd100, 11'd469, 8'hFF, "bracket_bot"};
    vecs[14] = '{11'd10,  11'd5,   8'hE0, "outside_bracket"};
    vecs[15] = '{11'd33,  11'd419, 8'h61, "band3_odd"};

    resetN       = 1'b0;
    pixelX       = 11'd5;
    pixelY       = 11'd5;
    startOfFrame = 1'b0;
    scrollEn     = 1'b0;
    scrollDir    = 1'b0;
    flashReq     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", {24'd0, BG_RGB}, 32'hFF);
    check("reset_busy", {31'd0, flashBusy}, 32'd0);
    resetN = 1'b1;

    // First edge after release produces the colour of pixel (5,5): band 0, even stripe.
    px_cycle(11'd5, 11'd5);
    check("first_after_reset", {24'd0, BG_RGB}, 32'hE0);

    for (int i = 0; i < 16; i++) begin
      px_cycle(vecs[i].x, vecs[i].y);
      check(vecs[i].name, {24'd0, BG_RGB}, {24'd0, vecs[i].exp});
    end

    // Scrolling: offset 32 moves pixel 40 to column 72 (even stripe).
    scrollEn  = 1'b1;
    scrollDir = 1'b0;
    repeat (32) sof_pulse();
    check("offset_32", {21'd0, dut.u_scroll.offset}, 32'd32);
    px_cycle(11'd40, 11'd200);
    check("stripe_off32", {24'd0, BG_RGB}, 32'h1C);

    repeat (607) sof_pulse();
    check("offset_639", {21'd0, dut.u_scroll.offset}, 32'd639);
    px_cycle(11'd32, 11'd200);
    check("stripe_off639", {24'd0, BG_RGB}, 32'h1C);

    sof_pulse();
    check("wrap_left", {21'd0, dut.u_scroll.offset}, 32'd0);
    px_cycle(11'd32, 11'd200);
    check("stripe_off0", {24'd0, BG_RGB}, 32'h0C);

    scrollDir = 1'b1;
    sof_pulse();
    check("wrap_right", {21'd0, dut.u_scroll.offset}, 32'd639);
    px_cycle(11'd32, 11'd200);
    check("stripe_right", {24'd0, BG_RGB}, 32'h1C);

    scrollEn = 1'b0;
    sof_pulse();
    check("freeze", {21'd0, dut.u_scroll.offset}, 32'd639);

    // Flash burst of 8 toggles, with a stray request mid-burst.
    flashReq = 1'b1;
    px_cycle(11'd0, 11'd100);
    flashReq = 1'b0;
    check("busy_start", {31'd0, flashBusy}, 32'd1);
    px_cycle(11'd0, 11'd100);
    check("flash_on_border", {24'd0, BG_RGB}, 32'h03);
    px_cycle(11'd10, 11'd100);
    check("flash_on_bracket", {24'd0, BG_RGB}, 32'h00);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        flashReq = 1'b1;
        px_cycle(11'd0, 11'd100);
        flashReq = 1'b0;
      end
      sof_pulse();
      px_cycle(11'd0, 11'd100);
      if (k < 8) begin
        check($sformatf("flash_border_%0d", k), {24'd0, BG_RGB}, (k % 2 == 0) ? 32'h03 : 32'hFC);
        check($sformatf("flash_busy_%0d", k), {31'd0, flashBusy}, 32'd1);
      end else begin
        check("flash_end_border", {24'd0, BG_RGB}, 32'hFC);
        check("flash_end_busy", {31'd0, flashBusy}, 32'd0);
      end
    end

    // Request and frame start together: enter ON with count 0, so 8 more toggles needed.
    flashReq     = 1'b1;
    startOfFrame = 1'b1;
    px_cycle(11'd0, 11'd100);
    flashReq     = 1'b0;
    startOfFrame = 1'b0;
    px_cycle(11'd0, 11'd100);
    check("same_cycle_on", {24'd0, BG_RGB}, 32'h03);
    repeat (7) sof_pulse();
    check("same_cycle_busy7", {31'd0, flashBusy}, 32'd1);
    sof_pulse();
    check("same_cycle_busy8", {31'd0, flashBusy}, 32'd0);

    // Asynchronous reset in the middle of a burst.
    flashReq = 1'b1;
    px_cycle(11'd5, 11'd5);
    flashReq = 1'b0;
    sof_pulse();
    sof_pulse();
    pixelX = 11'd5;
    pixelY = 11'd5;
    #2;
    resetN = 1'b0;
    #1;
    check("midburst_rgb", {24'd0, BG_RGB}, 32'hFF);
    check("midburst_busy", {31'd0, flashBusy}, 32'd0);
    @(posedge clk);
    #1;
    check("midburst_rgb_held", {24'd0, BG_RGB}, 32'hFF);
    resetN = 1'b1;
    check("midburst_offset", {21'd0, dut.u_scroll.offset}, 32'd0);
    px_cycle(11'd5, 11'd5);
    check("midburst_first", {24'd0, BG_RGB}, 32'hE0);
    check("midburst_busy_after", {31'd0, flashBusy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
